// File: rtl/payload_serializer.sv
// payload_serializer: word FIFO feeding an AXI-Stream byte serializer.
// Frames WORDS_PER_PKT words per payload with m_tlast; counts overflow drops.
module payload_serializer #(
  parameter int N_BYTES       = 9,
  parameter int BW_OUT        = 8,
  parameter int WORDS_PER_PKT = 128,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            srst_n,
  input  logic [N_BYTES-1:0][BW_OUT-1:0]  in_word,
  input  logic                            in_valid,
  output logic [BW_OUT-1:0]               m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [15:0]                     drop_cnt,
  output logic [15:0]                     pkt_cnt
);

  localparam int WW  = N_BYTES * BW_OUT;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BIW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int WIW = (WORDS_PER_PKT > 1) ?
                       $clog2(WORDS_PER_PKT) : 1;

  localparam logic [BIW-1:0] LAST_BYTE = BIW'(N_BYTES - 1);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(WORDS_PER_PKT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [WW-1:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [1:0]       r_state;
  logic [WW-1:0]    r_sreg;
  logic [BIW-1:0]   r_byte_idx;
  logic [WIW-1:0]   r_word_idx;
  logic             r_tvalid;
  logic             r_tlast;
  logic [15:0]      r_drop_cnt;
  logic [15:0]      r_pkt_cnt;

  logic [AW:0]      w_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_drop;
  logic             w_hs;
  logic             w_last_byte;
  logic             w_last_word;
  logic [WW-1:0]    w_head;

  logic             w_pop;
  logic             w_shift;
  logic             w_pkt_done;
  logic [1:0]       w_nstate;
  logic [BIW-1:0]   w_nbyte;
  logic [WIW-1:0]   w_nword;
  logic             w_ntlast;

  // Occupancy from the pointer difference; the extra MSB flags full.
  assign w_cnt       = r_wptr - r_rptr;
  assign w_full      = w_cnt[AW];
  assign w_empty     = (w_cnt == '0);
  assign w_push      = in_valid & ~w_full;
  assign w_drop      = in_valid & w_full;
  assign w_head      = r_mem[r_rptr[AW-1:0]];

  assign w_hs        = r_tvalid & m_tready;
  assign w_last_byte = (r_byte_idx == LAST_BYTE);
  assign w_last_word = (r_word_idx == LAST_WORD);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= in_word;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  // Next-state decode; the last byte of a word chains straight
  // into the next FIFO word so back-to-back words have no bubble.
  always_comb begin
    w_pop      = 1'b0;
    w_shift    = 1'b0;
    w_pkt_done = 1'b0;
    w_nstate   = r_state;
    w_nbyte    = r_byte_idx;
    w_nword    = r_word_idx;
    unique case (1'b1)
      (r_state == S_LOAD): begin
        w_pop    = 1'b1;
        w_nbyte  = '0;
        w_nstate = S_SEND;
      end
      (r_state == S_SEND): begin
        if (w_hs) begin
          if (w_last_byte) begin
            w_nbyte    = '0;
            w_pkt_done = w_last_word;
            w_nword    = w_last_word ? '0 :
                         r_word_idx + WIW'(1);
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_nstate = S_IDLE;
            end
          end else begin
            w_shift = 1'b1;
            w_nbyte = r_byte_idx + BIW'(1);
          end
        end
      end
      default: begin
        if (!w_empty) begin
          w_nstate = S_LOAD;
        end
      end
    endcase
  end

  assign w_ntlast = (w_nstate == S_SEND) &&
                    (w_nbyte == LAST_BYTE) &&
                    (w_nword == LAST_WORD);

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_word_idx <= '0;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_byte_idx <= w_nbyte;
      r_word_idx <= w_nword;
      r_tvalid   <= (w_nstate == S_SEND);
      r_tlast    <= w_ntlast;
    end
  end

  // Byte 0 sits in the low lane; each accepted byte shifts the next in.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_sreg <= '0;
    end else if (w_pop) begin
      r_sreg <= w_head;
    end else if (w_shift) begin
      r_sreg <= r_sreg >> BW_OUT;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      r_pkt_cnt <= '0;
    end else if (w_pkt_done) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign m_tdata  = r_sreg[BW_OUT-1:0];
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;
  assign drop_cnt = r_drop_cnt;
  assign pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_payload_serializer.sv
// tb_payload_serializer: directed vector table plus hand sequences
// for stall/overflow, random ready, mid-word reset and underrun.
module tb_payload_serializer;

  localparam int NB    = 9;
  localparam int WPP   = 4;
  localparam int DEPTH = 4;
  localparam int PKT_B = NB * WPP;
  localparam int NVEC  = 40;

  typedef logic [NB-1:0][7:0] word_t;

  typedef struct {
    logic       vin;
    logic [7:0] base;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       el;
  } vec_t;

  logic        clk;
  logic        srst_n;
  word_t       in_word;
  logic        in_valid;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [15:0] drop_cnt;
  logic [15:0] pkt_cnt;

  int          n_checks;
  int          n_errors;
  logic [7:0]  sb [$];
  int          pos;
  int          mpk;
  logic        p_stall;
  logic [7:0]  p_data;
  logic        p_last;
  vec_t        tbl [NVEC];
  word_t       rw;

  payload_serializer #(
    .N_BYTES       (NB),
    .BW_OUT        (8),
    .WORDS_PER_PKT (WPP),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .srst_n   (srst_n),
    .in_word  (in_word),
    .in_valid (in_valid),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .drop_cnt (drop_cnt),
    .pkt_cnt  (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic word_t mk(input logic [7:0] base);
    word_t w;
    for (int k = 0; k < NB; k++) w[k] = base + 8'(k);
    return w;
  endfunction

  task automatic enq(input word_t w);
    for (int k = 0; k < NB; k++) sb.push_back(w[k]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    tick();
    tick();
  endtask

  // Scoreboard: every accepted byte in order, tlast on byte PKT_B-1
  // of each payload, and no output change while stalled.
  task automatic monitor();
    logic [7:0] e;
    if (!srst_n) begin
      p_stall = 1'b0;
      return;
    end
    if (m_tlast && !m_tvalid) check("tlast_no_valid", 1, 0);
    if (p_stall) begin
      check("stall_valid", m_tvalid, 1);
      check("stall_data", m_tdata, p_data);
      check("stall_last", m_tlast, p_last);
    end
    if (m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("unexpected_byte", m_tdata, 0);
        n_errors += (m_tdata == 8'h00) ? 1 : 0;
      end else begin
        e = sb.pop_front();
        check("sb_data", m_tdata, e);
        check("sb_tlast", m_tlast, (pos == PKT_B - 1));
        if (pos == PKT_B - 1) begin
          pos = 0;
          mpk++;
        end else begin
          pos++;
        end
      end
    end
    p_stall = m_tvalid && !m_tready;
    p_data  = m_tdata;
    p_last  = m_tlast;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor();
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    pos      = 0;
    mpk      = 0;
    p_stall  = 1'b0;
    p_data   = '0;
    p_last   = 1'b0;
    srst_n   = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    m_tready = 1'b1;

    // One packet of four words, one word every NB cycles.
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].vin  = (i % NB == 0) && (i < 4 * NB);
      tbl[i].base = 8'(16 * (i / NB));
      tbl[i].rdy  = 1'b1;
      tbl[i].ev   = (i >= 3) && (i <= 4 * NB + 2);
      tbl[i].ed   = tbl[i].ev ?
                    8'(16 * ((i - 3) / NB) + (i - 3) % NB) : 8'h00;
      tbl[i].el   = (i == 4 * NB + 2);
    end

    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_pkt", pkt_cnt, 0);
    repeat (3) tick();
    srst_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      in_valid = tbl[i].vin;
      in_word  = mk(tbl[i].base);
      m_tready = tbl[i].rdy;
      if (tbl[i].vin) enq(in_word);
      @(negedge clk);
      check("tbl_tvalid", m_tvalid, tbl[i].ev);
      check("tbl_tlast", m_tlast, tbl[i].el);
      if (tbl[i].ev) check("tbl_tdata", m_tdata, tbl[i].ed);
      tick();
    end
    in_valid = 1'b0;
    check("tbl_pkt", pkt_cnt, 1);
    check("tbl_drop", drop_cnt, 0);

    // Stall with 7 back-to-back words: one in the output
    // register, four in the FIFO, two dropped.
    m_tready = 1'b0;
    for (int w = 0; w < 7; w++) begin
      in_valid = 1'b1;
      in_word  = mk(8'(8'h80 + 16 * w));
      if (w < 5) enq(in_word);
      tick();
    end
    in_valid = 1'b0;
    repeat (40) tick();
    check("stall_head", m_tdata, 8'h80);
    check("stall_tvalid", m_tvalid, 1);
    check("stall_drop", drop_cnt, 2);
    m_tready = 1'b1;
    drain(200);
    check("stall_pkt", pkt_cnt, 2);

    // Random words at a sustainable rate, random ready.
    for (int j = 0; j < 300; j++) begin
      for (int k = 0; k < NB; k++) rw[k] = 8'($urandom);
      in_valid = 1'b1;
      in_word  = rw;
      enq(rw);
      m_tready = 1'($urandom % 2);
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 35; c++) begin
        m_tready = 1'($urandom % 2);
        tick();
      end
    end
    m_tready = 1'b1;
    drain(400);
    check("rnd_drop", drop_cnt, 2);
    check("rnd_pkt", pkt_cnt, 32'(mpk));

    // Reset while byte 4 of a word is on the bus and one word queued.
    in_valid = 1'b1;
    in_word  = mk(8'h10);
    enq(in_word);
    tick();
    in_word  = mk(8'h30);
    enq(in_word);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("pre_rst_byte4", m_tdata, 8'h14);
    srst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_pkt", pkt_cnt, 0);
    sb.delete();
    pos     = 0;
    mpk     = 0;
    p_stall = 1'b0;
    tick();
    tick();
    srst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_rst_idle", m_tvalid, 0);
    end

    // Underrun: four words with idle gaps form one packet.
    for (int j = 0; j < 4; j++) begin
      in_valid = 1'b1;
      in_word  = mk(8'(8'h50 + 16 * j));
      enq(in_word);
      tick();
      in_valid = 1'b0;
      for (int c = 1; c < 30; c++) begin
        if (c == 20) check("gap_tvalid", m_tvalid, 0);
        tick();
      end
    end
    check("ur_sb_empty", sb.size(), 0);
    check("ur_pkt", pkt_cnt, 1);
    check("ur_model_pkt", 32'(mpk), 1);
    check("ur_drop", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
